// File: rtl/scan_pkg.sv
// Shared scan-path definitions: system-state code and loader state encoding.
package scan_pkg;

  localparam int unsigned SYS_STATE_W = 16;
  localparam int unsigned CFG_W       = 16;

  // system_state value that permits a frame start
  localparam logic [SYS_STATE_W-1:0] SCAN3D = 16'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_BUSY  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/scan_table_loader_if.sv
// Host write stream into the waveform tables: one word per valid&ready beat.
interface scan_table_loader_if #(
  parameter int unsigned DATA_W = 16
);

  logic              wr_valid;
  logic              wr_ready;
  logic              wr_sel;     // 0 = X table, 1 = Y table
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);

endinterface

// File: rtl/scan_table_ram.sv
// Simple dual-port table: one write port, one registered read port (read-old on collision).
module scan_table_ram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read, zeroed only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/scan_table_loader.sv
// Loads host-streamed X/Y galvo tables, validates point counts, and hands frames to the
// scan generator with a one-cycle frame_rdy pulse.
// Optional build macro: SCAN_TABLE_CHECKSUM_EN adds x_checksum/y_checksum outputs.
module scan_table_loader
  import scan_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [SYS_STATE_W-1:0] system_state,
  input  logic [CFG_W-1:0]       xdata_points_number,
  input  logic [CFG_W-1:0]       ydata_points_number,
  input  logic                   load_start,
  input  logic                   load_done,
  input  logic                   scan_start,
  input  logic                   proc_finished,
  input  logic [15:0]            sg_x_addr,
  input  logic [15:0]            sg_y_addr,
  scan_table_loader_if.slave     wr,
  output logic [DATA_W-1:0]      sg_x_data,
  output logic [DATA_W-1:0]      sg_y_data,
  output logic                   frame_rdy,
  output logic                   tables_valid,
  output logic                   busy,
  output logic                   err_overflow,
  output logic                   err_count,
  output logic [15:0]            frame_count
`ifdef SCAN_TABLE_CHECKSUM_EN
  ,
  output logic [15:0]            x_checksum,
  output logic [15:0]            y_checksum
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << ADDR_W;

  scan_state_e      state;
  logic [CNT_W-1:0] x_wcnt;
  logic [CNT_W-1:0] y_wcnt;

  logic load_clr_c;
  logic wr_fire_c;
  logic x_full_c;
  logic y_full_c;
  logic x_we_c;
  logic y_we_c;
  logic wr_drop_c;
  logic counts_ok_c;
  logic unused_addr_hi;

  // Upper read-address bits alias by design
  assign unused_addr_hi = ^{sg_x_addr[15:ADDR_W], sg_y_addr[15:ADDR_W]};

  // load_start is honoured everywhere except mid-frame
  assign load_clr_c  = load_start && (state != ST_BUSY);
  assign wr_fire_c   = wr.wr_valid && wr.wr_ready && !load_clr_c;
  assign x_full_c    = (CFG_W'(x_wcnt) == xdata_points_number) || (x_wcnt == CNT_FULL);
  assign y_full_c    = (CFG_W'(y_wcnt) == ydata_points_number) || (y_wcnt == CNT_FULL);
  assign x_we_c      = wr_fire_c && !wr.wr_sel && !x_full_c;
  assign y_we_c      = wr_fire_c &&  wr.wr_sel && !y_full_c;
  assign wr_drop_c   = wr_fire_c && (wr.wr_sel ? y_full_c : x_full_c);
  assign counts_ok_c = (CFG_W'(x_wcnt) == xdata_points_number) &&
                       (CFG_W'(y_wcnt) == ydata_points_number) &&
                       (x_wcnt != '0) && (y_wcnt != '0);

  // Loader FSM with write counters, sticky errors and registered status outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      wr.wr_ready  <= 1'b0;
      x_wcnt       <= '0;
      y_wcnt       <= '0;
      frame_rdy    <= 1'b0;
      tables_valid <= 1'b0;
      busy         <= 1'b0;
      err_overflow <= 1'b0;
      err_count    <= 1'b0;
      frame_count  <= '0;
    end else begin
      frame_rdy <= 1'b0;

      if (load_clr_c) begin
        x_wcnt       <= '0;
        y_wcnt       <= '0;
        err_overflow <= 1'b0;
        err_count    <= 1'b0;
      end else begin
        if (x_we_c)    x_wcnt <= x_wcnt + CNT_W'(1);
        if (y_we_c)    y_wcnt <= y_wcnt + CNT_W'(1);
        if (wr_drop_c) err_overflow <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (load_clr_c) begin
            state       <= ST_LOAD;
            wr.wr_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (!load_clr_c && load_done) begin
            wr.wr_ready <= 1'b0;
            if (counts_ok_c) begin
              state        <= ST_READY;
              tables_valid <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              err_count <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (load_clr_c) begin
            state        <= ST_LOAD;
            wr.wr_ready  <= 1'b1;
            tables_valid <= 1'b0;
          end else if (scan_start && (system_state == SCAN3D)) begin
            state     <= ST_BUSY;
            busy      <= 1'b1;
            frame_rdy <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (proc_finished) begin
            state       <= ST_READY;
            busy        <= 1'b0;
            frame_count <= frame_count + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_TABLE_CHECKSUM_EN
  // Running modulo-2^16 sums of the words accepted in the current load
  always_ff @(posedge sys_clk) begin
    if (sys_rst || load_clr_c) begin
      x_checksum <= '0;
      y_checksum <= '0;
    end else begin
      if (x_we_c) x_checksum <= x_checksum + 16'(wr.wr_data);
      if (y_we_c) y_checksum <= y_checksum + 16'(wr.wr_data);
    end
  end
`endif

  scan_table_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_x_ram (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .we    (x_we_c),
    .waddr (x_wcnt[ADDR_W-1:0]),
    .wdata (wr.wr_data),
    .raddr (sg_x_addr[ADDR_W-1:0]),
    .rdata (sg_x_data)
  );

  scan_table_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_y_ram (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .we    (y_we_c),
    .waddr (y_wcnt[ADDR_W-1:0]),
    .wdata (wr.wr_data),
    .raddr (sg_y_addr[ADDR_W-1:0]),
    .rdata (sg_y_data)
  );

endmodule

// File: tb/tb_scan_table_loader.sv
// Directed bench for scan_table_loader: loads, count checks, overflow, frame handshake, reset.
module tb_scan_table_loader;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] system_state = 16'd0;
  logic [15:0] xdata_points_number = 16'd4;
  logic [15:0] ydata_points_number = 16'd2;
  logic        load_start = 1'b0;
  logic        load_done = 1'b0;
  logic        scan_start = 1'b0;
  logic        proc_finished = 1'b0;
  logic [15:0] sg_x_addr = 16'd0;
  logic [15:0] sg_y_addr = 16'd0;
  logic [15:0] sg_x_data;
  logic [15:0] sg_y_data;
  logic        frame_rdy;
  logic        tables_valid;
  logic        busy;
  logic        err_overflow;
  logic        err_count;
  logic [15:0] frame_count;
`ifdef SCAN_TABLE_CHECKSUM_EN
  logic [15:0] x_checksum;
  logic [15:0] y_checksum;
`endif

  int checks = 0;
  int errors = 0;

  scan_table_loader_if #(.DATA_W(16)) wr_if ();

  scan_table_loader #(.ADDR_W(12), .DATA_W(16)) dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .system_state        (system_state),
    .xdata_points_number (xdata_points_number),
    .ydata_points_number (ydata_points_number),
    .load_start          (load_start),
    .load_done           (load_done),
    .scan_start          (scan_start),
    .proc_finished       (proc_finished),
    .sg_x_addr           (sg_x_addr),
    .sg_y_addr           (sg_y_addr),
    .wr                  (wr_if.slave),
    .sg_x_data           (sg_x_data),
    .sg_y_data           (sg_y_data),
    .frame_rdy           (frame_rdy),
    .tables_valid        (tables_valid),
    .busy                (busy),
    .err_overflow        (err_overflow),
    .err_count           (err_count),
    .frame_count         (frame_count)
`ifdef SCAN_TABLE_CHECKSUM_EN
    ,
    .x_checksum          (x_checksum),
    .y_checksum          (y_checksum)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(input logic sel, input logic [15:0] data);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_sel   = sel;
    wr_if.wr_data  = data;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_load_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_sel   = 1'b0;
    wr_if.wr_data  = 16'd0;

    // Reset state
    tick();
    tick();
    check("rst_sg_x_data", 32'(sg_x_data), 32'h0);
    sys_rst = 1'b0;
    tick();
    check("rst_tables_valid", 32'(tables_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_rdy", 32'(frame_rdy), 32'h0);
    check("rst_errs", 32'({err_overflow, err_count}), 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);
    check("rst_wr_ready", 32'(wr_if.wr_ready), 32'h0);

    // Good load: X = 1,2,3,4  Y = 9,8
    pulse_load_start();
    check("load_wr_ready", 32'(wr_if.wr_ready), 32'h1);
    wr_word(1'b0, 16'd1);
    wr_word(1'b0, 16'd2);
    wr_word(1'b0, 16'd3);
    wr_word(1'b0, 16'd4);
    wr_word(1'b1, 16'd9);
    wr_word(1'b1, 16'd8);
    pulse_load_done();
    check("good_tables_valid", 32'(tables_valid), 32'h1);
    check("good_wr_ready", 32'(wr_if.wr_ready), 32'h0);
    check("good_errs", 32'({err_overflow, err_count}), 32'h0);
    sg_x_addr = 16'd2;
    sg_y_addr = 16'd1;
    tick();
    check("read_x2", 32'(sg_x_data), 32'd3);
    check("read_y1", 32'(sg_y_data), 32'd8);
    sg_x_addr = 16'h1002;
    tick();
    check("read_x_alias", 32'(sg_x_data), 32'd3);

    // Frame start gated by system_state
    system_state = 16'd2;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("gated_frame_rdy", 32'(frame_rdy), 32'h0);
    check("gated_busy", 32'(busy), 32'h0);
    system_state = 16'd3;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("start_frame_rdy", 32'(frame_rdy), 32'h1);
    check("start_busy", 32'(busy), 32'h1);
    tick();
    check("pulse_width", 32'(frame_rdy), 32'h0);
    check("still_busy", 32'(busy), 32'h1);
    pulse_load_start();
    check("busy_ignores_load", 32'({busy, tables_valid, wr_if.wr_ready}), 32'b110);
    proc_finished = 1'b1;
    tick();
    proc_finished = 1'b0;
    check("finish_busy", 32'(busy), 32'h0);
    check("frame_count_1", 32'(frame_count), 32'd1);

    // proc_finished coincident with frame_rdy
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("frame2_rdy", 32'(frame_rdy), 32'h1);
    proc_finished = 1'b1;
    tick();
    proc_finished = 1'b0;
    check("frame2_done", 32'({busy, frame_rdy}), 32'b00);
    check("frame_count_2", 32'(frame_count), 32'd2);

    // load_start beats scan_start in READY
    load_start = 1'b1;
    scan_start = 1'b1;
    tick();
    load_start = 1'b0;
    scan_start = 1'b0;
    check("collide_no_rdy", 32'({frame_rdy, busy}), 32'b00);
    check("collide_load", 32'({tables_valid, wr_if.wr_ready}), 32'b01);

    // Count mismatch: 5 of 6 X words
    xdata_points_number = 16'd6;
    wr_word(1'b0, 16'd10);
    wr_word(1'b0, 16'd11);
    wr_word(1'b0, 16'd12);
    wr_word(1'b0, 16'd13);
    wr_word(1'b0, 16'd14);
    wr_word(1'b1, 16'd20);
    wr_word(1'b1, 16'd21);
    pulse_load_done();
    check("mismatch_err_count", 32'(err_count), 32'h1);
    check("mismatch_valid", 32'(tables_valid), 32'h0);
    check("mismatch_idle", 32'(wr_if.wr_ready), 32'h0);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("idle_no_rdy", 32'({frame_rdy, busy}), 32'b00);

    // Overflow: 5th X word with points=4, plus read-during-write
    xdata_points_number = 16'd4;
    pulse_load_start();
    check("clear_err_count", 32'(err_count), 32'h0);
    sg_x_addr = 16'd0;
    wr_word(1'b0, 16'd5);
    check("rdw_old_data", 32'(sg_x_data), 32'd10);
    wr_word(1'b0, 16'd6);
    check("rdw_new_data", 32'(sg_x_data), 32'd5);
    wr_word(1'b0, 16'd7);
    wr_word(1'b0, 16'd8);
    check("no_overflow_yet", 32'(err_overflow), 32'h0);
    wr_word(1'b0, 16'd99);
    check("overflow_set", 32'(err_overflow), 32'h1);
    wr_word(1'b1, 16'd1);
    wr_word(1'b1, 16'd2);
    pulse_load_done();
    check("ovf_load_valid", 32'({tables_valid, err_overflow, err_count}), 32'b110);
`ifdef SCAN_TABLE_CHECKSUM_EN
    check("x_checksum", 32'(x_checksum), 32'd26);
    check("y_checksum", 32'(y_checksum), 32'd3);
`endif
    sg_x_addr = 16'd4;
    tick();
    check("x4_unchanged", 32'(sg_x_data), 32'd14);
    sg_x_addr = 16'd3;
    tick();
    check("x3_loaded", 32'(sg_x_data), 32'd8);

    // Reset mid-frame
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("pre_reset_busy", 32'(busy), 32'h1);
    sys_rst = 1'b1;
    tick();
    check("reset_busy", 32'({busy, frame_rdy, tables_valid}), 32'b000);
    check("reset_frame_count", 32'(frame_count), 32'd0);
    sys_rst = 1'b0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("post_reset_idle", 32'({frame_rdy, busy, wr_if.wr_ready}), 32'b000);

    // Zero point counts never validate
    xdata_points_number = 16'd0;
    ydata_points_number = 16'd0;
    pulse_load_start();
    pulse_load_done();
    check("zero_points_err", 32'({err_count, tables_valid}), 32'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
